// File: rtl/router_fsm.sv
// Packet-flow controller for the 1x3 router: decodes the header address, sequences
// header/payload/parity loading and drives the register-stage strobes, FIFO write enable and busy.
module router_fsm #(
    parameter int DATA_W   = 8,
    parameter int NUM_DEST = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              write_enb_reg,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              rst_int_reg,
    output logic              busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_t;

    state_t     state, next_state;
    logic [1:0] addr_q;
    logic [1:0] addr_in;
    logic       addr_valid;
    logic [3:0] empty_vec;
    logic [3:0] soft_vec;
    logic       unused_data;

    assign addr_in     = data_in[1:0];
    assign addr_valid  = (int'(addr_in) < NUM_DEST);
    // Bit 3 pads the invalid address so indexing by any 2-bit address is safe.
    assign empty_vec   = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec    = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign unused_data = ^data_in[DATA_W-1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr_q <= addr_in;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS:
                if (pkt_valid && addr_valid)
                    next_state = empty_vec[addr_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
                next_state = LOAD_DATA;
            LOAD_DATA:
                if (fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    next_state = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!fifo_full)
                    next_state = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (parity_done)
                    next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            LOAD_PARITY:
                next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
                if (empty_vec[addr_q])
                    next_state = LOAD_FIRST_DATA;
            default:
                next_state = DECODE_ADDRESS;
        endcase
        // Timeout of the active destination aborts the packet from any non-idle state.
        if (state != DECODE_ADDRESS && soft_vec[addr_q])
            next_state = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        laf_state     = (state == LOAD_AFTER_FULL);
        full_state    = (state == FIFO_FULL_STATE);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed packet scenarios followed by randomized traffic, all checked against a
// transition-table reference model of the router controller.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
    logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy;

    int errors = 0;
    int checks = 0;

    localparam int S_DA = 0, S_LFD = 1, S_LD = 2, S_FFS = 3, S_LAF = 4, S_LP = 5,
                   S_CPE = 6, S_WTE = 7;

    int         m_st   = S_DA;
    int         m_addr = 0;

    router_fsm #(.DATA_W(8), .NUM_DEST(3)) dut (
        .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    // Output vector {write_enb, detect_add, lfd, ld, laf, full, rst_int, busy} per state.
    function automatic logic [7:0] exp_vec(input int s);
        case (s)
            S_DA:    return 8'b0100_0000;
            S_LFD:   return 8'b0010_0001;
            S_LD:    return 8'b1001_0000;
            S_FFS:   return 8'b0000_0101;
            S_LAF:   return 8'b1000_1001;
            S_LP:    return 8'b1000_0001;
            S_CPE:   return 8'b0000_0011;
            default: return 8'b0000_0001;
        endcase
    endfunction

    function automatic logic [7:0] dut_vec();
        return {write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
                full_state, rst_int_reg, busy};
    endfunction

    task automatic model_reset();
        m_st   = S_DA;
        m_addr = 0;
    endtask

    task automatic model_step();
        logic [2:0] emp;
        logic [2:0] sr;
        int nxt;
        int a;
        emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        sr  = {soft_reset_2, soft_reset_1, soft_reset_0};
        nxt = m_st;
        if (m_st != S_DA && m_addr < 3 && sr[m_addr]) begin
            nxt = S_DA;
        end else begin
            case (m_st)
                S_DA: if (pkt_valid) begin
                    a = int'(data_in[1:0]);
                    m_addr = a;
                    if (a < 3) nxt = emp[a] ? S_LFD : S_WTE;
                end
                S_LFD: nxt = S_LD;
                S_LD:  nxt = fifo_full ? S_FFS : (!pkt_valid ? S_LP : S_LD);
                S_FFS: nxt = fifo_full ? S_FFS : S_LAF;
                S_LAF: nxt = parity_done ? S_DA : (low_pkt_valid ? S_LP : S_LD);
                S_LP:  nxt = S_CPE;
                S_CPE: nxt = fifo_full ? S_FFS : S_DA;
                default: if (emp[m_addr]) nxt = S_LFD;
            endcase
        end
        m_st = nxt;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] got, want;
        got  = dut_vec();
        want = exp_vec(m_st);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: outputs got=%b expected=%b (model state %0d)", tag, got, want, m_st);
        end
    endtask

    task automatic expect_state(input string tag, input int s);
        logic [7:0] got;
        got = dut_vec();
        checks++;
        assert (got === exp_vec(s)) else begin
            errors++;
            $error("FAIL %s: outputs got=%b expected=%b", tag, got, exp_vec(s));
        end
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got=%b expected=%b", tag, got, want);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    initial begin
        // 1: reset and release
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        expect_state("reset_held", S_DA);
        #2 reset = 1'b0;
        tick("after_reset");
        expect_bit("reset_busy", busy, 1'b0);
        expect_bit("reset_wen", write_enb_reg, 1'b0);

        // 2: addr 2 packet, 4 payload bytes, parity
        pkt_valid = 1'b1; data_in = 8'h12; fifo_empty_2 = 1'b1;
        tick("p2_hdr");      expect_state("p2_lfd", S_LFD);
        data_in = 8'hA1;
        tick("p2_d0");       expect_state("p2_ld0", S_LD);
        for (int i = 1; i < 4; i++) begin
            data_in = 8'(i);
            tick("p2_dn");   expect_state("p2_ldn", S_LD);
        end
        pkt_valid = 1'b0; data_in = 8'h5C;
        tick("p2_par");      expect_state("p2_lp", S_LP);
        tick("p2_cpe");      expect_state("p2_cpe", S_CPE);
        expect_bit("p2_rst_int", rst_int_reg, 1'b1);
        tick("p2_done");     expect_state("p2_da", S_DA);
        expect_bit("p2_rst_int_clr", rst_int_reg, 1'b0);

        // 3: addr 1 waits for its FIFO to drain
        pkt_valid = 1'b1; data_in = 8'h01; fifo_empty_1 = 1'b0;
        tick("p3_hdr");      expect_state("p3_wte0", S_WTE);
        for (int i = 0; i < 2; i++) begin
            tick("p3_wait"); expect_state("p3_wte", S_WTE);
            expect_bit("p3_busy", busy, 1'b1);
        end
        fifo_empty_1 = 1'b1;
        tick("p3_go");       expect_state("p3_lfd", S_LFD);

        // 4: FIFO fills mid-packet, then pkt_valid fell while full
        tick("p4_ld");       expect_state("p4_ld", S_LD);
        fifo_full = 1'b1;
        tick("p4_full");     expect_state("p4_ffs", S_FFS);
        tick("p4_hold");     expect_state("p4_ffs2", S_FFS);
        fifo_full = 1'b0;
        tick("p4_laf");      expect_state("p4_laf", S_LAF);
        low_pkt_valid = 1'b1; parity_done = 1'b0; pkt_valid = 1'b0;
        tick("p4_lp");       expect_state("p4_lp", S_LP);
        low_pkt_valid = 1'b0;
        tick("p4_cpe");      expect_state("p4_cpe", S_CPE);
        tick("p4_da");       expect_state("p4_da", S_DA);

        // 5: soft reset of another port ignored, own port aborts
        pkt_valid = 1'b1; data_in = 8'h00; fifo_empty_0 = 1'b1;
        tick("p5_hdr");      expect_state("p5_lfd", S_LFD);
        tick("p5_ld");       expect_state("p5_ld", S_LD);
        soft_reset_1 = 1'b1;
        tick("p5_other");    expect_state("p5_ignored", S_LD);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        tick("p5_own");      expect_state("p5_abort", S_DA);
        soft_reset_0 = 1'b0; pkt_valid = 1'b0;
        tick("p5_idle");

        // 6: invalid address 3 is never accepted
        pkt_valid = 1'b1; data_in = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick("p6_bad");  expect_state("p6_da", S_DA);
            expect_bit("p6_busy", busy, 1'b0);
            expect_bit("p6_wen", write_enb_reg, 1'b0);
        end

        // 7: asynchronous reset mid-packet
        data_in = 8'h02;
        tick("p7_hdr");
        tick("p7_ld");       expect_state("p7_ld", S_LD);
        #2 reset = 1'b1;
        #1 model_reset();
        expect_state("p7_async", S_DA);
        pkt_valid = 1'b0;
        #1 reset = 1'b0;
        tick("p7_after");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            pkt_valid     = ($urandom % 4) != 0;
            data_in       = 8'($urandom);
            fifo_full     = ($urandom % 4) == 0;
            fifo_empty_0  = ($urandom % 3) != 0;
            fifo_empty_1  = ($urandom % 3) != 0;
            fifo_empty_2  = ($urandom % 3) != 0;
            soft_reset_0  = ($urandom % 20) == 0;
            soft_reset_1  = ($urandom % 20) == 0;
            soft_reset_2  = ($urandom % 20) == 0;
            parity_done   = ($urandom % 4) == 0;
            low_pkt_valid = ($urandom % 4) == 0;
            if (($urandom % 200) == 0) begin
                reset = 1'b1;
                #1 model_reset();
                check_model("rnd_reset");
                #1 reset = 1'b0;
            end
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
